// File: rtl/traffic_pkg.sv
// Shared light codes, controller state encoding and default dwell times
// for the intersection controller.
package traffic_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b001;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5,
    PED_WALK  = 3'd6
  } state_t;

  localparam int DEF_CNT_W        = 8;
  localparam int DEF_GREEN_TICKS  = 8;
  localparam int DEF_YELLOW_TICKS = 3;
  localparam int DEF_ALLRED_TICKS = 2;
  localparam int DEF_WALK_TICKS   = 6;

endpackage

// File: rtl/phase_timer.sv
// Dwell timer: counts tick strobes within one phase and flags the last one.
// Saturates on the final count so a held phase keeps reporting done.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             tick_en,
  input  logic [CNT_W-1:0] dwell,
  output logic             done
);

  logic [CNT_W-1:0] count;
  logic             at_end;

  assign at_end = (count == dwell - CNT_W'(1));
  assign done   = tick_en && at_end;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (tick_en && !at_end) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/intersection_controller.sv
// Two-head traffic light sequencer with EW car sensor and pedestrian walk phase.
// NS green is the rest state; all light outputs are a pure decode of the state.
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int ALLRED_TICKS = DEF_ALLRED_TICKS,
  parameter int WALK_TICKS   = DEF_WALK_TICKS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  input  logic       ped_req,
  input  logic       ew_car,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] phase
);

  state_t           state;
  state_t           state_next;
  logic             next_dir;
  logic             done;
  logic             enter_walk;
  logic [CNT_W-1:0] dwell;

  assign enter_walk = (state_next == PED_WALK) && (state != PED_WALK);
  assign phase      = state;

  always_comb begin
    dwell = CNT_W'(ALLRED_TICKS);
    case (state)
      NS_GREEN, EW_GREEN:   dwell = CNT_W'(GREEN_TICKS);
      NS_YELLOW, EW_YELLOW: dwell = CNT_W'(YELLOW_TICKS);
      PED_WALK:             dwell = CNT_W'(WALK_TICKS);
      default:              dwell = CNT_W'(ALLRED_TICKS);
    endcase
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_next != state),
    .tick_en (tick_en),
    .dwell   (dwell),
    .done    (done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ALL_RED_2;
    end else begin
      state <= state_next;
    end
  end

  // Entering the walk clears the request even if the button is pressed on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ped_pending <= 1'b0;
      next_dir    <= 1'b0;
    end else begin
      if (enter_walk) begin
        ped_pending <= 1'b0;
        next_dir    <= (state == ALL_RED_1);
      end else if (ped_req) begin
        ped_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    ns_light   = RED;
    ew_light   = RED;
    walk       = 1'b0;
    case (state)
      NS_GREEN: begin
        ns_light = GREEN;
        if (done && (ew_car || ped_pending)) state_next = NS_YELLOW;
      end
      NS_YELLOW: begin
        ns_light = YELLOW;
        if (done) state_next = ALL_RED_1;
      end
      ALL_RED_1: begin
        if (done) state_next = ped_pending ? PED_WALK : EW_GREEN;
      end
      EW_GREEN: begin
        ew_light = GREEN;
        if (done) state_next = EW_YELLOW;
      end
      EW_YELLOW: begin
        ew_light = YELLOW;
        if (done) state_next = ALL_RED_2;
      end
      ALL_RED_2: begin
        if (done) state_next = ped_pending ? PED_WALK : NS_GREEN;
      end
      PED_WALK: begin
        walk = 1'b1;
        if (done) state_next = next_dir ? EW_GREEN : NS_GREEN;
      end
      default: begin
        state_next = ALL_RED_2;
      end
    endcase
  end

endmodule

// File: tb/tb_intersection_controller.sv
// Randomised and directed bench for intersection_controller against a
// tick-counting behavioural model of the phase sequence.
module tb_intersection_controller;
  import traffic_pkg::*;

  localparam int G  = 4;
  localparam int Y  = 2;
  localparam int AR = 1;
  localparam int W  = 3;

  logic       clk;
  logic       rst_n;
  logic       tick_en;
  logic       ped_req;
  logic       ew_car;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  int total;
  int passed;

  int m_phase;
  int m_elapsed;
  bit m_pend;
  bit m_walk_to_ew;

  intersection_controller #(
    .CNT_W        (8),
    .GREEN_TICKS  (G),
    .YELLOW_TICKS (Y),
    .ALLRED_TICKS (AR),
    .WALK_TICKS   (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_en     (tick_en),
    .ped_req     (ped_req),
    .ew_car      (ew_car),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .walk        (walk),
    .ped_pending (ped_pending),
    .phase       (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int dwell_of(input int p);
    case (p)
      0, 3:    return G;
      1, 4:    return Y;
      2, 5:    return AR;
      6:       return W;
      default: return 1;
    endcase
  endfunction

  function automatic logic [2:0] exp_ns(input int p);
    if (p == 0) return GREEN;
    if (p == 1) return YELLOW;
    return RED;
  endfunction

  function automatic logic [2:0] exp_ew(input int p);
    if (p == 3) return GREEN;
    if (p == 4) return YELLOW;
    return RED;
  endfunction

  function automatic logic [10:0] model_vec();
    return {3'(m_phase), exp_ns(m_phase), exp_ew(m_phase), (m_phase == 6), m_pend};
  endfunction

  // Model counts elapsed strobes in the current phase and moves on once the dwell is used up.
  task automatic model_step(input bit r, input bit t, input bit p, input bit c);
    int  nxt;
    bit  finished;
    if (!r) begin
      m_phase   = 5;
      m_elapsed = 0;
      m_pend    = 0;
      return;
    end
    nxt      = m_phase;
    finished = t && (m_elapsed + 1 >= dwell_of(m_phase));
    if (m_phase == 7) nxt = 5;
    else if (finished) begin
      case (m_phase)
        0: if (c || m_pend) nxt = 1;
        1: nxt = 2;
        2: nxt = m_pend ? 6 : 3;
        3: nxt = 4;
        4: nxt = 5;
        5: nxt = m_pend ? 6 : 0;
        6: nxt = m_walk_to_ew ? 3 : 0;
        default: nxt = 5;
      endcase
    end
    if (nxt == 6 && m_phase != 6) begin
      m_walk_to_ew = (m_phase == 2);
      m_pend       = 0;
    end else if (p) begin
      m_pend = 1;
    end
    if (nxt != m_phase) m_elapsed = 0;
    else if (t) m_elapsed++;
    m_phase = nxt;
  endtask

  task automatic cycle(input bit r, input bit t, input bit p, input bit c);
    rst_n   = r;
    tick_en = t;
    ped_req = p;
    ew_car  = c;
    @(posedge clk);
    model_step(r, t, p, c);
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 1, 0, 1);
    total++;
    if ({phase, ns_light, ew_light, walk, ped_pending} !== {3'd5, RED, RED, 1'b0, 1'b0})
      $display("[TB] FAIL reset_state got=%h want=%h", {phase, ns_light, ew_light, walk, ped_pending},
               {3'd5, RED, RED, 1'b0, 1'b0});
    else passed++;
  endtask

  task automatic test_cycle();
    logic [2:0] pat [14];
    pat = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5};
    cycle(0, 1, 0, 1);
    for (int i = 0; i < 28; i++) begin
      cycle(1, 1, 0, 1);
      total++;
      if (phase !== pat[i % 14])
        $display("[TB] FAIL cycle_phase step=%0d got=%0d want=%0d", i, phase, pat[i % 14]);
      else passed++;
      total++;
      if (ns_light != RED && ew_light != RED)
        $display("[TB] FAIL cycle_safety step=%0d ns=%b ew=%b", i, ns_light, ew_light);
      else passed++;
    end
  endtask

  task automatic test_hold();
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 50; i++) cycle(1, 1, 0, 0);
    total++;
    if (ns_light !== GREEN) $display("[TB] FAIL hold_green got=%b want=%b", ns_light, GREEN);
    else passed++;
    cycle(1, 1, 0, 1);
    total++;
    if (ns_light !== YELLOW) $display("[TB] FAIL hold_release got=%b want=%b", ns_light, YELLOW);
    else passed++;
  endtask

  task automatic test_ped();
    int n;
    int walks;
    cycle(0, 1, 0, 1);
    n = 0;
    while (phase !== 3'd3 && n < 40) begin
      cycle(1, 1, 0, 1);
      n++;
    end
    total++;
    if (phase !== 3'd3) $display("[TB] FAIL ped_reach_ew got=%0d want=3", phase);
    else passed++;
    cycle(1, 1, 1, 0);
    total++;
    if (ped_pending !== 1'b1) $display("[TB] FAIL ped_latch got=%b want=1", ped_pending);
    else passed++;
    walks = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 0, 0);
      if (walk === 1'b1) walks++;
      total++;
      if ({phase, ns_light, ew_light, walk, ped_pending} !== model_vec())
        $display("[TB] FAIL ped_seq step=%0d got=%h want=%h", i,
                 {phase, ns_light, ew_light, walk, ped_pending}, model_vec());
      else passed++;
    end
    total++;
    if (walks != W || phase !== 3'd0)
      $display("[TB] FAIL ped_walk_len got=%0d/%0d want=%0d/0", walks, phase, W);
    else passed++;
  endtask

  task automatic test_rearm();
    int n;
    int walks;
    cycle(0, 1, 0, 0);
    n = 0;
    while (walk !== 1'b1 && n < 30) begin
      cycle(1, 1, 1, 0);
      n++;
    end
    total++;
    if (walk !== 1'b1) $display("[TB] FAIL rearm_first_walk got=%b want=1", walk);
    else passed++;
    cycle(1, 1, 1, 0);
    cycle(1, 1, 1, 0);
    total++;
    if (ped_pending !== 1'b1) $display("[TB] FAIL rearm_pending got=%b want=1", ped_pending);
    else passed++;
    walks = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 0, 0);
      if (walk === 1'b1) walks++;
      total++;
      if ({phase, ns_light, ew_light, walk, ped_pending} !== model_vec())
        $display("[TB] FAIL rearm_seq step=%0d got=%h want=%h", i,
                 {phase, ns_light, ew_light, walk, ped_pending}, model_vec());
      else passed++;
    end
    total++;
    if (walks != W) $display("[TB] FAIL rearm_second_walk got=%0d want=%0d", walks, W);
    else passed++;
  endtask

  task automatic test_entry_drop();
    int n;
    cycle(0, 1, 0, 1);
    n = 0;
    while (phase !== 3'd3 && n < 40) begin
      cycle(1, 1, 0, 1);
      n++;
    end
    cycle(1, 1, 1, 1);
    n = 0;
    while (phase !== 3'd5 && n < 40) begin
      cycle(1, 1, 0, 1);
      n++;
    end
    total++;
    if (phase !== 3'd5) $display("[TB] FAIL drop_reach_allred got=%0d want=5", phase);
    else passed++;
    cycle(1, 1, 1, 1);
    total++;
    if ({walk, ped_pending} !== 2'b10)
      $display("[TB] FAIL drop_entry_edge got=%b want=10", {walk, ped_pending});
    else passed++;
  endtask

  task automatic test_slow_tick();
    bit t;
    bit c;
    bit p;
    cycle(0, 1, 0, 1);
    for (int i = 0; i < 240; i++) begin
      t = (i % 4 == 3);
      c = (($urandom % 3) != 0);
      p = (($urandom % 16) == 0);
      cycle(1, t, p, c);
      total++;
      if ({phase, ns_light, ew_light, walk, ped_pending} !== model_vec())
        $display("[TB] FAIL slow_tick step=%0d got=%h want=%h", i,
                 {phase, ns_light, ew_light, walk, ped_pending}, model_vec());
      else passed++;
    end
  endtask

  task automatic test_midreset();
    int n;
    cycle(0, 1, 0, 1);
    n = 0;
    while (phase !== 3'd3 && n < 40) begin
      cycle(1, 1, 0, 1);
      n++;
    end
    cycle(1, 0, 1, 1);
    cycle(0, 1, 0, 1);
    total++;
    if ({phase, ns_light, ew_light, walk, ped_pending} !== {3'd5, RED, RED, 1'b0, 1'b0})
      $display("[TB] FAIL midreset got=%h want=%h", {phase, ns_light, ew_light, walk, ped_pending},
               {3'd5, RED, RED, 1'b0, 1'b0});
    else passed++;
    cycle(1, 1, 0, 1);
    total++;
    if (phase !== 3'd0) $display("[TB] FAIL midreset_resume got=%0d want=0", phase);
    else passed++;
  endtask

  task automatic test_illegal();
    cycle(0, 1, 0, 1);
    cycle(1, 1, 0, 1);
    force dut.state = state_t'(3'd7);
    #1;
    total++;
    if ({phase, ns_light, ew_light} !== {3'd7, RED, RED})
      $display("[TB] FAIL illegal_decode got=%h want=%h", {phase, ns_light, ew_light}, {3'd7, RED, RED});
    else passed++;
    release dut.state;
    m_phase   = 7;
    m_elapsed = 0;
    cycle(1, 1, 0, 1);
    total++;
    if ({phase, ns_light, ew_light} !== {3'd5, RED, RED})
      $display("[TB] FAIL illegal_recover got=%h want=%h", {phase, ns_light, ew_light}, {3'd5, RED, RED});
    else passed++;
  endtask

  task automatic test_random();
    bit r;
    bit t;
    bit p;
    bit c;
    c = 1'b0;
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      r = (($urandom % 200) != 0);
      t = (($urandom % 3) != 0);
      p = (($urandom % 10) == 0);
      if (($urandom % 8) == 0) c = ~c;
      cycle(r, t, p, c);
      total++;
      if ({phase, ns_light, ew_light, walk, ped_pending} !== model_vec())
        $display("[TB] FAIL random step=%0d got=%h want=%h", i,
                 {phase, ns_light, ew_light, walk, ped_pending}, model_vec());
      else passed++;
      total++;
      if (ns_light != RED && ew_light != RED)
        $display("[TB] FAIL random_safety step=%0d ns=%b ew=%b", i, ns_light, ew_light);
      else passed++;
    end
  endtask

  initial begin
    total        = 0;
    passed       = 0;
    m_phase      = 5;
    m_elapsed    = 0;
    m_pend       = 0;
    m_walk_to_ew = 0;
    rst_n        = 1'b0;
    tick_en      = 1'b0;
    ped_req      = 1'b0;
    ew_car       = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_cycle();
    test_hold();
    test_ped();
    test_rearm();
    test_entry_drop();
    test_slow_tick();
    test_midreset();
    test_illegal();
    test_random();
    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
